// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// One outstanding word read at a time: req/gnt for the address phase,
// rvalid/rdata for the data phase.
interface if_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID register.
// Owns the PC, issues single-word reads to imem, holds the fetched word while
// the hazard unit stalls, and squashes stale fetches on branch/jump redirects.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// ST_FETCH | request asserted at pc, waiting for grant
// ST_WAIT  | grant accepted, waiting for rvalid (drop=1: response is stale)
// ST_HOLD  | valid instruction presented to IF/ID until PC_Write or redirect
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   PC_Write,
   input  logic                   redirect_valid,
   input  logic [31:0]            redirect_pc,
   if_fetch_unit_if.master        imem,
   output logic [31:0]            instr_out,
   output logic [31:0]            pc_out,
   output logic                   fetch_valid
);

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   // Low address bits are never meaningful for word fetches.
   localparam logic [31:0] WORD_MASK    = 32'hFFFF_FFFC;
   localparam logic [31:0] RESET_PC_ALN = RESET_PC & WORD_MASK;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        drop_q, drop_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_out_q, pc_out_d;
   logic        valid_q, valid_d;

   logic [31:0] pc_plus4;
   logic [31:0] redirect_aln;

   assign pc_plus4     = pc_q + 32'd4;
   assign redirect_aln = redirect_pc & WORD_MASK;

   // Next-state, PC and output-register computation; redirect overrides
   // everything but reset, and a still-outstanding grant is marked for drop.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      drop_d   = drop_q;
      instr_d  = instr_q;
      pc_out_d = pc_out_q;
      valid_d  = valid_q;

      if (redirect_valid) begin
         pc_d     = redirect_aln;
         valid_d  = 1'b0;
         instr_d  = NOP_INSTR;
         pc_out_d = 32'd0;
         unique case (state_q)
            ST_FETCH: begin
               if (imem.imem_gnt) begin
                  state_d = ST_WAIT;
                  drop_d  = 1'b1;
               end else begin
                  state_d = ST_FETCH;
               end
            end
            ST_WAIT: begin
               if (imem.imem_rvalid) begin
                  state_d = ST_FETCH;
                  drop_d  = 1'b0;
               end else begin
                  state_d = ST_WAIT;
                  drop_d  = 1'b1;
               end
            end
            ST_HOLD: begin
               state_d = ST_FETCH;
            end
            default: begin
               state_d = ST_FETCH;
               drop_d  = 1'b0;
            end
         endcase
      end else begin
         unique case (state_q)
            ST_FETCH: begin
               // rvalid here can only be a response abandoned by reset.
               if (imem.imem_gnt) begin
                  state_d = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (imem.imem_rvalid) begin
                  if (drop_q) begin
                     drop_d  = 1'b0;
                     state_d = ST_FETCH;
                  end else begin
                     instr_d  = imem.imem_rdata;
                     pc_out_d = pc_plus4;
                     valid_d  = 1'b1;
                     state_d  = ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (PC_Write) begin
                  pc_d     = pc_plus4;
                  valid_d  = 1'b0;
                  instr_d  = NOP_INSTR;
                  pc_out_d = 32'd0;
                  state_d  = ST_FETCH;
               end
            end
            default: begin
               state_d = ST_FETCH;
               drop_d  = 1'b0;
            end
         endcase
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_FETCH;
         pc_q     <= RESET_PC_ALN;
         drop_q   <= 1'b0;
         instr_q  <= NOP_INSTR;
         pc_out_q <= 32'd0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         drop_q   <= drop_d;
         instr_q  <= instr_d;
         pc_out_q <= pc_out_d;
         valid_q  <= valid_d;
      end
   end

   // Request only from FETCH and never while reset is asserted.
   assign imem.imem_req  = rst_n && (state_q == ST_FETCH);
   assign imem.imem_addr = pc_q;

   assign instr_out   = instr_q;
   assign pc_out      = pc_out_q;
   assign fetch_valid = valid_q;

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the program counter and issues word reads to instruction memory over a req/gnt/rvalid handshake.
- Presents the fetched instruction and PC+4 to IF/ID, and holds them while the hazard unit stalls.
- Accepts branch/jump redirects from downstream and squashes any stale in-flight fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset (bits [1:0] must be 0).
- NOP_INSTR, 32'h0000_0000, bubble value driven on instr_out when no valid instruction is held.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- PC_Write  in  1  hazard-unit advance enable; 1 = IF/ID consumes instr_out/pc_out this cycle.
- redirect_valid  in  1  branch/jump taken; overrides everything except reset.
- redirect_pc  in  32  redirect target; bits [1:0] ignored and forced to 0.
- imem_req  out  1  fetch request.
- imem_addr  out  32  word-aligned fetch address (= pc).
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid (1..N cycles after grant, one response per grant).
- imem_rdata  in  32  instruction word.
- instr_out  out  32  instruction to IF/ID; NOP_INSTR when fetch_valid=0.
- pc_out  out  32  address of instr_out + 4; 0 when fetch_valid=0.
- fetch_valid  out  1  instr_out/pc_out hold a real instruction.

Behaviour:
- Reset (rst_n=0 at posedge):
  - pc=RESET_PC, state=FETCH, drop=0, fetch_valid=0, instr_out=NOP_INSTR, pc_out=0.
  - imem_req is deasserted for that cycle.
  - Reset mid-WAIT abandons the outstanding response; an rvalid arriving later in FETCH is ignored.
- States: FETCH, WAIT, HOLD.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - gnt=1 -> WAIT; gnt=0 -> stay in FETCH with addr held stable.
  - imem_rvalid is ignored in this state.
- WAIT:
  - imem_req=0.
  - On rvalid with drop=0: instr_out<=imem_rdata, pc_out<=pc+4, fetch_valid<=1, -> HOLD.
  - On rvalid with drop=1: discard data, drop<=0, -> FETCH.
- HOLD:
  - Outputs stable; no requests issued.
  - PC_Write=1: pc<=pc+4, fetch_valid<=0, instr_out<=NOP_INSTR, pc_out<=0, -> FETCH.
  - PC_Write=0: stay in HOLD, all outputs unchanged.
- Redirect (redirect_valid=1 at posedge; takes priority over PC_Write and rvalid):
  - pc<={redirect_pc[31:2],2'b00}, fetch_valid<=0, instr_out<=NOP_INSTR, pc_out<=0.
  - Next state depends on whether a response is still outstanding:
    - FETCH with gnt=0 -> FETCH.
    - FETCH with gnt=1 (a grant is now outstanding) -> WAIT, drop<=1.
    - WAIT with rvalid=0 -> WAIT, drop<=1.
    - WAIT with rvalid=1 -> FETCH, data discarded, drop<=0.
    - HOLD -> FETCH; the held instruction is squashed.
  - Back-to-back redirects: the last one wins; drop stays 1 until the outstanding response returns.
- Latency:
  - Grant at cycle t, rvalid at t+k -> fetch_valid=1 visible after the posedge ending cycle t+k.
  - Minimum 3 cycles per instruction (FETCH, WAIT, HOLD) with k=1 and no stalls.
- Arithmetic: pc+4 wraps modulo 2^32; 32'hFFFF_FFFC advances to 32'h0000_0000.
- At most one outstanding request at any time; imem_req is never asserted in WAIT or HOLD.

Test Plan:
- Reset then run, 1-cycle memory, PC_Write=1:
  - imem_addr sequence 0x0, 0x4, 0x8 with one request every 3 cycles.
  - pc_out sequence 0x4, 0x8, 0xC, each with fetch_valid=1 for one cycle.
- Stall: PC_Write=0 for 4 cycles while in HOLD with instr 0x8C220004 at pc 0x10:
  - instr_out=0x8C220004 and pc_out=0x14 stay stable; no imem_req.
  - Release -> next imem_addr=0x14.
- Grant backpressure: imem_gnt=0 for 3 cycles in FETCH:
  - imem_req stays 1 and imem_addr stays constant until gnt.
- Redirect in WAIT (redirect_pc=0x103) with the response 2 cycles later:
  - That response is discarded, fetch_valid stays 0.
  - Next imem_addr=0x100.
- Redirect in the same cycle as rvalid: data discarded, state=FETCH, imem_addr=redirect target next cycle. Redirect in HOLD with PC_Write=1: the redirect wins and pc does not become held pc+4.
- Wrap and reset:
  - pc=0xFFFF_FFFC advances to 0x0 with pc_out=0x0.
  - rst_n=0 mid-WAIT followed by a late rvalid -> ignored; first imem_addr=RESET_PC.
